// File: rtl/Purple_Jade_pkg.sv
// Shared widths and arbiter state encoding for the data-memory port.
package Purple_Jade_pkg;

   localparam int WORD_SIZE_P = 32;
   localparam int SB_ENTRY    = 8;

   typedef enum logic {
      LOAD_PRI = 1'b0,
      DRAIN    = 1'b1
   } arb_state_e;

endpackage : Purple_Jade_pkg

// File: rtl/dmem_port_arbiter.sv
// Arbitrates one single-port synchronous data memory between execute loads
// and store-buffer drains.
//
// Handshake: a requester transfers in a cycle only when its valid and its
// ready are both high in that cycle. A ready never depends on its own
// requester's valid, only on the other valid, the arbiter state, the
// starvation counter, the flush and reset.
//
// LOAD_PRI lets loads win conflicts until a store has been denied
// STARVE_LIMIT_P cycles in a row. DRAIN lets stores win every conflict.
// A sole valid requester is always served. Load data returns one cycle after
// the grant straight from the memory, and a flush in that cycle drops it.
module dmem_port_arbiter #(
   parameter int WORD_SIZE_P    = Purple_Jade_pkg::WORD_SIZE_P,
   parameter int HI_WATER_P     = Purple_Jade_pkg::SB_ENTRY - 2,
   parameter int LO_WATER_P     = 2,
   parameter int STARVE_LIMIT_P = 4
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic                                     ld_v_i,
   input  logic [WORD_SIZE_P-1:0]                   ld_addr_i,
   output logic                                     ld_ready_o,
   output logic                                     ld_resp_v_o,
   output logic [WORD_SIZE_P-1:0]                   ld_resp_data_o,
   input  logic                                     st_v_i,
   input  logic [WORD_SIZE_P-1:0]                   st_addr_i,
   input  logic [WORD_SIZE_P-1:0]                   st_data_i,
   output logic                                     st_ready_o,
   input  logic [$clog2(Purple_Jade_pkg::SB_ENTRY):0] sb_count_i,
   input  logic                                     rob_mispredict_i,
   output logic                                     mem_v_o,
   output logic                                     mem_w_o,
   output logic [WORD_SIZE_P-1:0]                   mem_addr_o,
   output logic [WORD_SIZE_P-1:0]                   mem_data_o,
   input  logic [WORD_SIZE_P-1:0]                   mem_data_i,
   output logic                                     drain_mode_o
);

   import Purple_Jade_pkg::*;

   localparam int SB_CNT_W = $clog2(SB_ENTRY) + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT_P + 1);

   localparam logic [SB_CNT_W-1:0] HI_WATER    = SB_CNT_W'(HI_WATER_P);
   localparam logic [SB_CNT_W-1:0] LO_WATER    = SB_CNT_W'(LO_WATER_P);
   localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT_P);

   arb_state_e          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                ld_resp_v_q, ld_resp_v_d;

   logic                store_wins;
   logic                ld_req;
   logic                ld_grant;
   logic                st_grant;

   // Next state: hysteresis between the high and low water marks.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD_PRI: if (sb_count_i >= HI_WATER) state_d = DRAIN;
         DRAIN:    if (sb_count_i <= LO_WATER) state_d = LOAD_PRI;
         default:  state_d = LOAD_PRI;
      endcase
   end

   // Readies, grants and memory command; a flushed load cannot transfer,
   // so it never blocks a store. Reset holds both readies low.
   always_comb begin
      store_wins = (state_q == DRAIN) || (starve_q == STARVE_MAX);
      ld_req     = ld_v_i && !rob_mispredict_i;

      ld_ready_o = !reset_i && !rob_mispredict_i && (!st_v_i || !store_wins);
      st_ready_o = !reset_i && (!ld_req || store_wins);

      ld_grant   = ld_v_i && ld_ready_o;
      st_grant   = st_v_i && st_ready_o;

      mem_v_o    = 1'b0;
      mem_w_o    = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      if (st_grant) begin
         mem_v_o    = 1'b1;
         mem_w_o    = 1'b1;
         mem_addr_o = st_addr_i;
         mem_data_o = st_data_i;
      end else if (ld_grant) begin
         mem_v_o    = 1'b1;
         mem_addr_o = ld_addr_i;
      end
   end

   // Starvation counter: counts consecutive denied store cycles, saturating.
   always_comb begin
      starve_d = '0;
      if (st_v_i && !st_grant) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
      end
      ld_resp_v_d = ld_grant;
   end

   // State, starvation counter and response-pending flag.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= LOAD_PRI;
         starve_q    <= '0;
         ld_resp_v_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         ld_resp_v_q <= ld_resp_v_d;
      end
   end

   // Response: memory data arrives one cycle after the grant.
   always_comb begin
      ld_resp_v_o    = ld_resp_v_q && !rob_mispredict_i;
      ld_resp_data_o = mem_data_i;
      drain_mode_o   = (state_q == DRAIN);
   end

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous memory model.
module tb_dmem_port_arbiter;

   localparam int W  = 32;
   localparam int CW = $clog2(Purple_Jade_pkg::SB_ENTRY) + 1;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic reset_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic          ld_v_i, ld_ready_o, ld_resp_v_o;
   logic [W-1:0]  ld_addr_i, ld_resp_data_o;
   logic          st_v_i, st_ready_o;
   logic [W-1:0]  st_addr_i, st_data_i;
   logic [CW-1:0] sb_count_i;
   logic          rob_mispredict_i;
   logic          mem_v_o, mem_w_o, drain_mode_o;
   logic [W-1:0]  mem_addr_o, mem_data_o, mem_data_i;

   dmem_port_arbiter dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .ld_v_i           (ld_v_i),
      .ld_addr_i        (ld_addr_i),
      .ld_ready_o       (ld_ready_o),
      .ld_resp_v_o      (ld_resp_v_o),
      .ld_resp_data_o   (ld_resp_data_o),
      .st_v_i           (st_v_i),
      .st_addr_i        (st_addr_i),
      .st_data_i        (st_data_i),
      .st_ready_o       (st_ready_o),
      .sb_count_i       (sb_count_i),
      .rob_mispredict_i (rob_mispredict_i),
      .mem_v_o          (mem_v_o),
      .mem_w_o          (mem_w_o),
      .mem_addr_o       (mem_addr_o),
      .mem_data_o       (mem_data_o),
      .mem_data_i       (mem_data_i),
      .drain_mode_o     (drain_mode_o)
   );

   // ---------------- memory model ----------------
   // Untouched word at address a reads as 0xA000_0000 | a.
   logic [W-1:0] mem [0:255];
   bit mem_init_done = 1'b0;
   always @(posedge clk_i) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
         mem_init_done <= 1'b1;
         mem_data_i    <= '0;
      end else if (mem_v_o) begin
         if (mem_w_o) mem[mem_addr_o[7:0]] <= mem_data_o;
         else         mem_data_i <= mem[mem_addr_o[7:0]];
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic lv, input logic [W-1:0] la,
                        input logic sv, input logic [W-1:0] sa, input logic [W-1:0] sd);
      ld_v_i    = lv;
      ld_addr_i = la;
      st_v_i    = sv;
      st_addr_i = sa;
      st_data_i = sd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      ld_v_i = 0; ld_addr_i = '0; st_v_i = 0; st_addr_i = '0; st_data_i = '0;
      sb_count_i = '0; rob_mispredict_i = 0;
      step(); step(); #1;

      // reset state
      check("rst_drain", drain_mode_o, 0);
      check("rst_resp_v", ld_resp_v_o, 0);
      check("rst_mem_v", mem_v_o, 0);

      // first cycle after reset: load vs store conflict, load wins
      reset_i = 1'b0;
      sb_count_i = 1;
      drive(1'b1, 32'h10, 1'b1, 32'h20, 32'h55);
      check("conf_ld_ready", ld_ready_o, 1);
      check("conf_st_ready", st_ready_o, 0);
      check("conf_mem_v", mem_v_o, 1);
      check("conf_mem_w", mem_w_o, 0);
      check("conf_mem_addr", mem_addr_o, 32'h10);
      step(); idle();
      check("conf_resp_v", ld_resp_v_o, 1);
      check("conf_resp_data", ld_resp_data_o, 32'hA000_0010);
      step();
      check("idle_resp_v", ld_resp_v_o, 0);
      check("idle_mem_v", mem_v_o, 0);

      // write then read
      drive(1'b0, '0, 1'b1, 32'h30, 32'hBEEF);
      check("wr_st_ready", st_ready_o, 1);
      check("wr_mem_w", mem_w_o, 1);
      check("wr_mem_addr", mem_addr_o, 32'h30);
      check("wr_mem_data", mem_data_o, 32'hBEEF);
      step(); drive(1'b1, 32'h30, 1'b0, '0, '0);
      check("rd_ld_ready", ld_ready_o, 1);
      step(); idle();
      check("rd_resp_v", ld_resp_v_o, 1);
      check("rd_resp_data", ld_resp_data_o, 32'hBEEF);

      // drain-mode hysteresis
      sb_count_i = 6;
      #1;
      check("hi_same_cycle", drain_mode_o, 0);
      step();
      check("hi_drain", drain_mode_o, 1);
      drive(1'b1, 32'h10, 1'b1, 32'h40, 32'h1234);
      check("drain_st_ready", st_ready_o, 1);
      check("drain_ld_ready", ld_ready_o, 0);
      check("drain_mem_w", mem_w_o, 1);
      check("drain_mem_addr", mem_addr_o, 32'h40);
      drive(1'b1, 32'h10, 1'b0, '0, '0);
      check("drain_sole_ld", ld_ready_o, 1);
      idle();
      sb_count_i = 3;
      step();
      check("mid_water_drain", drain_mode_o, 1);
      sb_count_i = 2;
      #1;
      check("lo_same_cycle", drain_mode_o, 1);
      step();
      check("lo_exit", drain_mode_o, 0);

      // starvation: four denied cycles, store forced on the fifth
      sb_count_i = 1;
      for (int c = 1; c <= 4; c++) begin
         drive(1'b1, 32'h10, 1'b1, 32'h60, 32'h77);
         check($sformatf("starve_ld_c%0d", c), ld_ready_o, 1);
         check($sformatf("starve_st_c%0d", c), st_ready_o, 0);
         step();
      end
      drive(1'b1, 32'h10, 1'b1, 32'h60, 32'h77);
      check("starve_st_c5", st_ready_o, 1);
      check("starve_ld_c5", ld_ready_o, 0);
      check("starve_mem_w_c5", mem_w_o, 1);
      step();
      drive(1'b1, 32'h10, 1'b1, 32'h60, 32'h77);
      check("starve_clr_ld", ld_ready_o, 1);
      check("starve_clr_st", st_ready_o, 0);
      step(); idle(); step();

      // flush: load at t, mispredict at t+1 with a store in flight
      drive(1'b1, 32'h10, 1'b0, '0, '0);
      check("fl_ld_ready", ld_ready_o, 1);
      step();
      rob_mispredict_i = 1'b1;
      drive(1'b1, 32'h10, 1'b1, 32'h50, 32'hCAFE);
      check("fl_resp_v", ld_resp_v_o, 0);
      check("fl_ld_ready", ld_ready_o, 0);
      check("fl_st_ready", st_ready_o, 1);
      check("fl_mem_w", mem_w_o, 1);
      check("fl_mem_addr", mem_addr_o, 32'h50);
      step();
      rob_mispredict_i = 1'b0;
      idle();
      check("fl_after_resp_v", ld_resp_v_o, 0);
      drive(1'b1, 32'h50, 1'b0, '0, '0);
      step(); idle();
      check("fl_store_kept", ld_resp_data_o, 32'hCAFE);

      // reset mid-operation while in DRAIN with a load response pending
      sb_count_i = 6;
      step();
      check("pre_rst_drain", drain_mode_o, 1);
      drive(1'b1, 32'h10, 1'b0, '0, '0);
      step();
      check("pre_rst_resp_v", ld_resp_v_o, 1);
      reset_i = 1'b1;
      #1;
      check("async_resp_v", ld_resp_v_o, 0);
      check("async_drain", drain_mode_o, 0);
      check("async_mem_v", mem_v_o, 0);
      check("async_ld_ready", ld_ready_o, 0);
      step();
      check("rst_edge_resp_v", ld_resp_v_o, 0);
      idle();
      sb_count_i = 0;
      reset_i = 1'b0;
      step();
      check("post_rst_resp_v", ld_resp_v_o, 0);
      check("post_rst_drain", drain_mode_o, 0);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dmem_port_arbiter

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE_P, default package WORD_SIZE_P; address and data width.
REQ-002 SHALL have parameter HI_WATER_P, default SB_ENTRY-2; store-buffer occupancy that enters drain mode.
REQ-003 SHALL have parameter LO_WATER_P, default 2; store-buffer occupancy that exits drain mode.
REQ-004 SHALL have parameter STARVE_LIMIT_P, default 4; consecutive denied store cycles before a store is forced.
REQ-005 SHALL have port clk_i, input, 1; the single clock, rising edge.
REQ-006 SHALL have port reset_i, input, 1; asynchronous, active-high reset.
REQ-007 SHALL have ports ld_v_i (in, 1), ld_addr_i (in, WORD_SIZE_P) and ld_ready_o (out, 1); load request from execute.
REQ-008 SHALL have ports ld_resp_v_o (out, 1) and ld_resp_data_o (out, WORD_SIZE_P); load response.
REQ-009 SHALL have ports st_v_i (in, 1), st_addr_i (in, WORD_SIZE_P), st_data_i (in, WORD_SIZE_P) and st_ready_o (out, 1); store-buffer drain request.
REQ-010 SHALL have port sb_count_i, input, $clog2(SB_ENTRY)+1; store-buffer occupancy.
REQ-011 SHALL have port rob_mispredict_i, input, 1; flush.
REQ-012 SHALL have ports mem_v_o, mem_w_o (out, 1), mem_addr_o and mem_data_o (out, WORD_SIZE_P), and mem_data_i (in, WORD_SIZE_P); single-port synchronous memory with 1-cycle read latency.
REQ-013 SHALL have port drain_mode_o, output, 1; the current FSM state is DRAIN.

Function
REQ-014 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high in the same cycle.
REQ-015 SHALL implement a 2-state FSM.
- LOAD_PRI: the load wins a conflict.
- DRAIN: the store wins a conflict.
REQ-016 SHALL move LOAD_PRI->DRAIN when sb_count_i >= HI_WATER_P, and DRAIN->LOAD_PRI when sb_count_i <= LO_WATER_P; both take effect the next cycle.
REQ-017 SHALL keep a starvation counter in LOAD_PRI.
- Increments when st_v_i=1 and the store is not granted.
- Clears on a store grant, or when st_v_i=0.
- At STARVE_LIMIT_P, the store wins the conflict in that cycle.
REQ-018 SHALL compute ld_ready_o and st_ready_o combinationally from the valids, the state and the starvation counter; a ready SHALL NOT depend on that requester's own valid.
REQ-019 SHALL, on a store grant, drive mem_v_o=1, mem_w_o=1, mem_addr_o=st_addr_i and mem_data_o=st_data_i in the same cycle.
REQ-020 SHALL, on a load grant in cycle t, drive mem_v_o=1, mem_w_o=0 and mem_addr_o=ld_addr_i in t, and assert ld_resp_v_o in t+1 with ld_resp_data_o=mem_data_i.
REQ-021 SHALL force ld_ready_o=0 while rob_mispredict_i=1, and SHALL suppress ld_resp_v_o in t+1 when rob_mispredict_i=1 in t+1.
REQ-022 SHALL leave store drain unaffected by rob_mispredict_i; committed stores are never flushed.
REQ-023 SHALL grant the sole requester when only one requester is valid, regardless of state.
REQ-024 SHALL drive mem_v_o=0 and mem_w_o=0 when no grant occurs.
REQ-025 SHALL saturate the starvation counter at STARVE_LIMIT_P, with width $clog2(STARVE_LIMIT_P+1).

Reset
REQ-026 SHALL, asynchronously on reset_i=1, set state=LOAD_PRI, starvation counter=0, ld_resp_v_o=0, drain_mode_o=0 and mem_v_o=0.
REQ-027 SHALL never produce the response of a load granted in the cycle reset asserts.
REQ-028 SHALL allow the first grant in the first cycle after reset_i deasserts.

Structure
REQ-029 SHALL take WORD_SIZE_P and SB_ENTRY from Purple_Jade_pkg; the FSM state enum SHALL live in that package.
REQ-030 SHALL be a single flat module with no sub-modules; the memory instance stays in the parent.

Verification
REQ-031 SHALL cover a conflict: LOAD_PRI, sb_count_i=1, ld_v_i and st_v_i both 1 at 0x10 / 0x20 -> load granted, mem_addr_o=0x10, ld_resp_v_o high next cycle.
REQ-032 SHALL cover drain-mode hysteresis: sb_count_i=SB_ENTRY-2 -> drain_mode_o=1 next cycle, stores win conflicts; drop to 2 -> drain_mode_o=0 next cycle.
REQ-033 SHALL cover starvation: continuous loads plus st_v_i=1 for 5 cycles in LOAD_PRI (limit 4) -> store granted in cycle 5, counter cleared.
REQ-034 SHALL cover a flush: load granted at t with rob_mispredict_i=1 at t+1 -> ld_resp_v_o=0; the store grant at t+1 still writes.
REQ-035 SHALL cover write-then-read: store 0xBEEF to 0x30, then load 0x30 -> ld_resp_data_o=0xBEEF.
REQ-036 SHALL cover reset mid-operation: assert reset_i during a load grant -> ld_resp_v_o=0 and state=LOAD_PRI immediately, without waiting for a clock edge.
